// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared size and dump-state encodings for the memory stage
package mem_stage_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_READ = 2'd1,
        DUMP_SEND = 2'd2,
        DUMP_DONE = 2'd3
    } dump_state_t;

    // Size 2'b10 is not a legal encoding and behaves like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// rtl/mem_stage_data_mem.sv - word array with byte-lane write and two async read ports
module data_mem #(
    parameter  int NB_DATA  = 32,
    parameter  int NB_ADDR  = 10,
    localparam int NB_WADDR = NB_ADDR - 2,
    localparam int NB_LANES = NB_DATA / 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [NB_LANES-1:0] be,
    input  logic [NB_WADDR-1:0] waddr,
    input  logic [NB_DATA-1:0]  wdata,
    input  logic [NB_WADDR-1:0] raddr,
    output logic [NB_DATA-1:0]  rdata,
    input  logic [NB_WADDR-1:0] dump_raddr,
    output logic [NB_DATA-1:0]  dump_rdata
);

    localparam int DEPTH = 1 << NB_WADDR;

    // Contents are deliberately not reset so a dump after reset still sees them.
    logic [NB_DATA-1:0] mem [DEPTH];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB_LANES; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata      = mem[raddr];
    assign dump_rdata = mem[dump_raddr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with optional debug dump port (MEM_STAGE_DUMP_EN)
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_step,
    input  logic [NB_DATA-1:0]   i_alu_result,
    input  logic [NB_DATA-1:0]   i_store_data,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [1:0]           i_size,
    input  logic                 i_unsigned,
    input  logic [4:0]           i_reg2write,
    input  logic                 i_mem2reg,
    input  logic                 i_regWrite,
    output logic [NB_DATA-1:0]   o_reg_read,
    output logic [NB_DATA-1:0]   o_result,
    output logic [4:0]           o_reg2write,
    output logic                 o_mem2reg,
    output logic                 o_regWrite,
    output logic                 o_misaligned,
    input  logic                 i_dump_start,
    input  logic                 i_dump_ready,
    output logic                 o_dump_valid,
    output logic [NB_DATA-1:0]   o_dump_data,
    output logic [NB_ADDR-3:0]   o_dump_addr,
    output logic                 o_dump_busy,
    output logic                 o_dump_done
);

    localparam int NB_WADDR = NB_ADDR - 2;
    localparam int NB_LANES = NB_DATA / 8;

    logic [NB_ADDR-1:0]  addr;
    logic [1:0]          addr_lo;
    logic                misaligned;
    logic [NB_DATA-1:0]  rd_word;
    logic [NB_DATA-1:0]  shifted;
    logic [NB_DATA-1:0]  wr_data;
    logic [NB_LANES-1:0] wr_be;
    logic                store_en;
    logic                dump_busy;
    logic [NB_WADDR-1:0] dump_raddr;
    logic [NB_DATA-1:0]  dump_rdata;

    assign addr       = i_alu_result[NB_ADDR-1:0];
    assign addr_lo    = addr[1:0];
    assign misaligned = (i_mem_read | i_mem_write) & is_misaligned(i_size, addr_lo);

    assign o_misaligned = misaligned;
    assign o_result     = i_alu_result;
    assign o_reg2write  = i_reg2write;
    assign o_mem2reg    = i_mem2reg;
    assign o_regWrite   = i_regWrite & ~(i_mem_read & misaligned);

    // Bring the addressed lane down to bit 0 so extraction is size-only.
    assign shifted = rd_word >> {addr_lo, 3'b000};

    // Combinational load: pick lane(s), then sign- or zero-extend.
    always_comb begin
        o_reg_read = '0;
        if (i_mem_read && !misaligned) begin
            case (i_size)
                SIZE_BYTE: o_reg_read = {{(NB_DATA-8){~i_unsigned & shifted[7]}}, shifted[7:0]};
                SIZE_HALF: o_reg_read = {{(NB_DATA-16){~i_unsigned & shifted[15]}}, shifted[15:0]};
                default:   o_reg_read = rd_word;
            endcase
        end
    end

    // Replicate store data across lanes; the byte enables pick the real target.
    always_comb begin
        wr_data = i_store_data;
        wr_be   = '1;
        case (i_size)
            SIZE_BYTE: begin
                wr_data = {NB_LANES{i_store_data[7:0]}};
                wr_be   = NB_LANES'(1) << addr_lo;
            end
            SIZE_HALF: begin
                wr_data = {(NB_DATA/16){i_store_data[15:0]}};
                wr_be   = NB_LANES'(3) << addr_lo;
            end
            default: begin
                wr_data = i_store_data;
                wr_be   = '1;
            end
        endcase
    end

    // Reset gates the write so a store in flight when reset asserts is dropped.
    assign store_en = i_mem_write & ~i_step & ~misaligned & ~dump_busy & i_reset;

    data_mem #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_data_mem (
        .clk        (clk),
        .we         (store_en),
        .be         (wr_be),
        .waddr      (addr[NB_ADDR-1:2]),
        .wdata      (wr_data),
        .raddr      (addr[NB_ADDR-1:2]),
        .rdata      (rd_word),
        .dump_raddr (dump_raddr),
        .dump_rdata (dump_rdata)
    );

`ifdef MEM_STAGE_DUMP_EN

    localparam logic [NB_WADDR-1:0] LAST_WORD = '1;

    dump_state_t         state;
    logic [NB_WADDR-1:0] ptr;

    assign dump_raddr = ptr;
    assign dump_busy  = o_dump_busy;

    // Dump FSM: walk every word once, holding each on the port until accepted.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= DUMP_IDLE;
            ptr          <= '0;
            o_dump_valid <= 1'b0;
            o_dump_done  <= 1'b0;
            o_dump_busy  <= 1'b0;
            o_dump_data  <= '0;
            o_dump_addr  <= '0;
        end else begin
            case (state)
                DUMP_IDLE: begin
                    if (i_dump_start && i_step) begin
                        state       <= DUMP_READ;
                        ptr         <= '0;
                        o_dump_busy <= 1'b1;
                    end
                end
                DUMP_READ: begin
                    o_dump_data  <= dump_rdata;
                    o_dump_addr  <= ptr;
                    o_dump_valid <= 1'b1;
                    state        <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    if (i_dump_ready) begin
                        o_dump_valid <= 1'b0;
                        if (ptr == LAST_WORD) begin
                            state       <= DUMP_DONE;
                            o_dump_done <= 1'b1;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= DUMP_READ;
                        end
                    end
                end
                default: begin
                    o_dump_done <= 1'b0;
                    o_dump_busy <= 1'b0;
                    state       <= DUMP_IDLE;
                end
            endcase
        end
    end

`else

    logic unused_dump;

    assign dump_raddr   = '0;
    assign dump_busy    = 1'b0;
    assign o_dump_valid = 1'b0;
    assign o_dump_busy  = 1'b0;
    assign o_dump_done  = 1'b0;
    assign o_dump_data  = '0;
    assign o_dump_addr  = '0;
    assign unused_dump  = ^{i_dump_start, i_dump_ready, dump_rdata};

`endif

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter NB_DATA, default 32, SHALL set the datapath width.
REQ-002 Parameter NB_ADDR, default 10, SHALL set the byte-address width; memory depth SHALL be 2^(NB_ADDR-2) words.
REQ-003 clk  in  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 i_reset  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_step  in  1  SHALL indicate the pipeline is halted when 1; stores SHALL be blocked while it is 1.
REQ-006 i_alu_result  in  NB_DATA  SHALL carry the byte address (low NB_ADDR bits) and the pass-through result.
REQ-007 i_store_data  in  NB_DATA; i_mem_read  in  1; i_mem_write  in  1 SHALL carry the memory request.
REQ-008 i_size  in  2 (00 byte, 01 half, 11 word; 10 treated as word); i_unsigned  in  1 (zero-extend loads).
REQ-009 i_reg2write  in  5; i_mem2reg  in  1; i_regWrite  in  1 SHALL carry writeback control.
REQ-010 o_reg_read  out  NB_DATA; o_result  out  NB_DATA; o_reg2write  out  5; o_mem2reg  out  1; o_regWrite  out  1 SHALL feed the MEM/WB register.
REQ-011 o_misaligned  out  1 SHALL flag a misaligned access.
REQ-012 i_dump_start  in  1; i_dump_ready  in  1; o_dump_valid  out  1; o_dump_data  out  NB_DATA; o_dump_addr  out  NB_ADDR-2; o_dump_busy  out  1; o_dump_done  out  1 SHALL form the debug dump port.

Function
REQ-013 o_result, o_reg2write, o_mem2reg SHALL equal their inputs combinationally; o_regWrite SHALL equal i_regWrite AND NOT (i_mem_read AND o_misaligned).
REQ-014 o_misaligned SHALL be 1 when (i_mem_read or i_mem_write) and (half with addr[0]=1, or word with addr[1:0]!=0).
REQ-015 Loads SHALL be combinational: selected byte/half by addr[1:0], little-endian, sign- or zero-extended per i_unsigned; o_reg_read SHALL be 0 when i_mem_read=0 or misaligned.
REQ-016 A store SHALL commit at the clock edge when i_mem_write=1, i_step=0, o_misaligned=0, o_dump_busy=0, writing only the addressed byte lanes.
REQ-017 Dump FSM states IDLE, READ, SEND, DONE; reset state IDLE.
REQ-018 IDLE->READ when i_dump_start=1 and i_step=1; pointer cleared to 0; i_dump_start otherwise ignored.
REQ-019 READ: latch word[pointer] into o_dump_data, o_dump_addr=pointer, then SEND (one cycle).
REQ-020 SEND: o_dump_valid=1, data/addr stable until i_dump_ready=1; on handshake, last word -> DONE, else pointer+1 -> READ.
REQ-021 DONE: o_dump_done=1 for exactly one cycle, then IDLE.
REQ-022 o_dump_busy SHALL be 1 in READ, SEND, DONE; i_step falling during a dump SHALL NOT abort it, and stores SHALL stay blocked until IDLE.
REQ-023 Pointer SHALL not wrap: last word is 2^(NB_ADDR-2)-1.

Reset
REQ-024 On i_reset=0: FSM=IDLE, pointer=0, o_dump_valid=0, o_dump_done=0, o_dump_busy=0, o_dump_data=0, o_dump_addr=0, including mid-dump.
REQ-025 Memory contents SHALL NOT be cleared by reset; in-flight store at reset assertion SHALL NOT commit.

Configuration
REQ-026 Macro MEM_STAGE_DUMP_EN defined: dump FSM and port functional per REQ-017..023.
REQ-027 Macro undefined: no FSM; o_dump_valid, o_dump_busy, o_dump_done, o_dump_data, o_dump_addr tied 0; i_dump_* ignored; stores gated only by REQ-016 minus busy.

Structure
REQ-028 Shared package SHALL hold size encodings (SIZE_BYTE/HALF/WORD) and dump state encodings.
REQ-029 Sub-module data_mem SHALL hold the array with byte-enable synchronous write and combinational read port plus a second read port for dump.

Verification
REQ-030 Store word 0xDEADBEEF @0x010, load word unsigned @0x010 -> o_reg_read=0xDEADBEEF.
REQ-031 Load byte signed @0x013 -> 0xFFFFFFDE; unsigned -> 0x000000DE; half signed @0x012 -> 0xFFFFDEAD.
REQ-032 Store half @0x011 -> o_misaligned=1, memory unchanged, load of same access -> o_reg_read=0, o_regWrite=0.
REQ-033 i_step=1 with i_mem_write=1 @0x020 -> no write; i_step=0 next cycle -> write commits.
REQ-034 MEM_STAGE_DUMP_EN, NB_ADDR=4, i_step=1, pulse i_dump_start, i_dump_ready stalled 3 cycles on word 1 -> 4 handshakes addr 0..3 in order, data stable while stalled, one-cycle o_dump_done.
REQ-035 Assert i_reset=0 during SEND -> o_dump_valid=0, o_dump_busy=0 immediately; subsequent store with i_step=0 commits.
